// File: rtl/mskaes_ks_rcon_seq.sv
// Round sequencer for the masked AES-128 key schedule: steers the shared rcon
// generator and injects its constant into the SubWord result that seeds column 0.
module mskaes_ks_rcon_seq #(
    parameter int d  = 2,
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            inverse_in,
    output logic            busy,
    output logic            done,
    output logic            sbox_req,
    input  logic [32*d-1:0] sh_subw,
    input  logic            subw_valid,
    output logic            rcon_rst,
    output logic            rcon_update,
    output logic            rcon_mask,
    output logic            rcon_inverse,
    input  logic [8*d-1:0]  sh_rcon,
    output logic [32*d-1:0] sh_kw,
    output logic            kw_valid,
    output logic            col_en,
    output logic [1:0]      col_idx,
    output logic [3:0]      round
);

    generate
        if (NR < 1 || NR > 15 || d < 2) begin : g_param_check
            $error("mskaes_ks_rcon_seq: NR must be 1..15 and d must be >= 2");
        end
    endgenerate

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_COLS  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        col_r;
    logic [3:0]        round_r;
    logic              inv_r;
    logic [32*d-1:0]   sh_kw_r;
    logic              kw_valid_r;
    logic              last_col_s;
    logic              accept_s;

    assign last_col_s = (state_r == S_COLS) && (col_r == 2'd3);
    assign accept_s   = (state_r == S_WAIT) && subw_valid;

    // State register plus round/column counters and direction latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            col_r   <= 2'd0;
            round_r <= 4'd0;
            inv_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == S_WAIT) begin
                col_r <= 2'd1;
            end else if (state_r == S_COLS) begin
                col_r <= col_r + 2'd1;
            end else begin
                col_r <= 2'd0;
            end
            if (state_r == S_INIT) begin
                round_r <= 4'd1;
            end else if (last_col_s && (round_r != NR_L)) begin
                round_r <= round_r + 4'd1;
            end else begin
                round_r <= round_r;
            end
            if ((state_r == S_IDLE) && start) begin
                inv_r <= inverse_in;
            end else begin
                inv_r <= inv_r;
            end
        end
    end

    // Column-0 word capture: rcon is zero-extended so it lands only in byte 0 of every share slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_kw_r    <= '0;
            kw_valid_r <= 1'b0;
        end else begin
            kw_valid_r <= accept_s;
            if (accept_s) begin
                sh_kw_r <= sh_subw ^ {{(24*d){1'b0}}, sh_rcon};
            end else begin
                sh_kw_r <= sh_kw_r;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (start) state_s = S_INIT; else state_s = S_IDLE;
            S_INIT:  state_s = S_ISSUE;
            S_ISSUE: state_s = S_WAIT;
            S_WAIT:  if (subw_valid) state_s = S_COLS; else state_s = S_WAIT;
            S_COLS: begin
                if (col_r == 2'd3) begin
                    if (round_r == NR_L) state_s = S_DONE;
                    else                 state_s = S_ISSUE;
                end else begin
                    state_s = S_COLS;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the registered state; rcon is only ungated while waiting for SubWord
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        sbox_req    = 1'b0;
        rcon_rst    = 1'b0;
        rcon_update = 1'b0;
        rcon_mask   = 1'b0;
        col_en      = 1'b0;
        col_idx     = 2'd0;
        case (state_r)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_INIT: begin
                busy     = 1'b1;
                rcon_rst = 1'b1;
            end
            S_ISSUE: begin
                busy     = 1'b1;
                sbox_req = 1'b1;
            end
            S_WAIT: begin
                busy      = 1'b1;
                rcon_mask = 1'b1;
            end
            S_COLS: begin
                busy        = 1'b1;
                col_en      = 1'b1;
                col_idx     = col_r;
                rcon_update = last_col_s && (round_r != NR_L);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rcon_inverse = inv_r;
    assign sh_kw        = sh_kw_r;
    assign kw_valid     = kw_valid_r;
    assign round        = round_r;

endmodule
